rs_encoder: RTL and testbench
=============================

RS_ENCODER -- requirements
Module: rs_encoder

Interface
REQ-001 Parameter N, default 31: codeword length in symbols.
REQ-002 Parameter K, default 27: full message length in symbols; N-K = 4 parity symbols (t=2).
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 datain  input  5  message symbol; bit 4 is the MSB.
REQ-006 in_valid  input  1  datain valid this cycle.
REQ-007 in_ready  output  1  encoder accepts datain this cycle.
REQ-008 dataout  output  5  codeword symbol (registered).
REQ-009 out_valid  output  1  dataout valid.
REQ-010 out_ready  input  1  downstream accepts dataout.
REQ-011 out_sop  output  1  dataout is the first codeword symbol.
REQ-012 out_eop  output  1  dataout is the last parity symbol.

Function
REQ-013 Field GF(2^5), primitive polynomial x^5+x^2+1; addition is bitwise XOR.
REQ-014 Systematic code; generator g(x)=(x+a)(x+a^2)(x+a^3)(x+a^4) = x^4 + 30x^3 + 6x^2 + 9x + 17 (decimal symbols).
REQ-015 Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
REQ-016 FSM states: IDLE, DATA, PARITY.
REQ-017 IDLE: the first input transfer loads the first message symbol, sets out_sop, and moves to DATA.
REQ-018 DATA: accepts symbols until the Kth transfer, then moves to PARITY; the message-symbol counter counts 0..K-1.
REQ-019 Encoding LFSR, per accepted symbol: fb = datain^r3; r3<=r2^fb*g3; r2<=r1^fb*g2; r1<=r0^fb*g1; r0<=fb*g0.
REQ-020 Each accepted message symbol appears unchanged on dataout in the following cycle (latency 1).
REQ-021 PARITY: in_ready=0; emits r3, r2, r1, r0 in that order, one per output transfer, by shifting the LFSR with zero feedback.
REQ-022 PARITY: out_eop is set with r0; after r0 transfers, the LFSR clears and the FSM returns to IDLE.
REQ-023 in_ready = (state!=PARITY) && (!out_valid || out_ready); a stalled output holds dataout, out_sop and out_eop stable.
REQ-024 Back-to-back codewords are supported: an input transfer in the cycle r0 transfers starts the next codeword with no bubble.
REQ-025 in_valid deasserted mid-message pauses encoding; LFSR and counter hold their values.

Reset
REQ-026 Asynchronous reset_n low forces: state=IDLE, LFSR=0, counter=0, dataout=0, out_valid=0, out_sop=0, out_eop=0, in_ready=0.
REQ-027 Reset asserted mid-codeword abandons the partial codeword; the first transfer after reset starts a new codeword.
REQ-028 in_ready rises no earlier than the first clock edge after reset_n deasserts.

Configuration
REQ-029 Macro RSENC_SHORTEN_EN adds input port msg_len[4:0], sampled on the first transfer of each codeword; message length = msg_len (1..K), and the value 0 or values >K are treated as K.
REQ-030 With RSENC_SHORTEN_EN undefined, the msg_len port does not exist and the message length is fixed at K.
REQ-031 Parity symbols are identical to those of a full-length codeword with leading zero symbols.

Structure
REQ-032 Package rs_pkg holds: N, K, NPAR=4, the primitive polynomial, generator coefficients G0..G3, and the state enum.
REQ-033 One sub-module, rs_enc_lfsr: the 4-stage LFSR with constant GF multipliers, load/shift/clear controls, and parity outputs.
REQ-034 The FSM, handshake logic and output register reside in rs_encoder.

Verification
REQ-035 27 zero symbols, out_ready=1 -> 31 zero outputs; out_sop on output 1, out_eop on output 31.
REQ-036 26 zeros then 1 -> parity outputs 30, 6, 9, 17.
REQ-037 Random messages -> each codeword evaluates to 0 at a, a^2, a^3 and a^4 (checked by a reference model).
REQ-038 Random out_ready deassertion and random in_valid gaps -> no symbol lost or duplicated; dataout stable while stalled.
REQ-039 reset_n pulsed low at message symbol 10 -> outputs clear immediately; the next 27-symbol message encodes correctly.
REQ-040 RSENC_SHORTEN_EN, msg_len=1, datain=1 -> 5 outputs: 1, 30, 6, 9, 17; out_eop on output 5.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants for the RS(31,27) encoder over GF(2^5): field polynomial,
// generator coefficients, FSM states and a constant-friendly GF multiplier.
package rs_pkg;

  localparam int N     = 31;
  localparam int K     = 27;
  localparam int NPAR  = 4;
  localparam int SYM_W = 5;

  // x^5 + x^2 + 1
  localparam logic [SYM_W:0] PRIM_POLY = 6'b100101;

  // g(x) = x^4 + 30x^3 + 6x^2 + 9x + 17
  localparam logic [SYM_W-1:0] G0 = 5'd17;
  localparam logic [SYM_W-1:0] G1 = 5'd9;
  localparam logic [SYM_W-1:0] G2 = 5'd6;
  localparam logic [SYM_W-1:0] G3 = 5'd30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  function automatic logic [SYM_W-1:0] gen_coef(input int idx);
    case (idx)
      0:       return G0;
      1:       return G1;
      2:       return G2;
      default: return G3;
    endcase
  endfunction

  // With one operand constant this folds to a small XOR network.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[SYM_W-1] ? ({aa[SYM_W-2:0], 1'b0} ^ PRIM_POLY[SYM_W-1:0])
                       : {aa[SYM_W-2:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_enc_lfsr.sv
// Four-stage parity LFSR: load absorbs a message symbol, shift moves parity
// towards the head with zero feedback, clear zeroes the state (applied first).
module rs_enc_lfsr
  import rs_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [SYM_W-1:0]     sym_i,
  output logic [SYM_W-1:0]     par_head_o
);

  logic [NPAR-1:0][SYM_W-1:0] r_q;
  logic [NPAR-1:0][SYM_W-1:0] r_d;
  logic [NPAR-1:0][SYM_W-1:0] base;
  logic [SYM_W-1:0]           fb;

  // Clear acts on the current state so a load in the same cycle starts a
  // fresh codeword.
  assign base = clear_i ? '0 : r_q;
  assign fb   = sym_i ^ base[NPAR-1];

  genvar gi;
  generate
    for (gi = 0; gi < NPAR; gi++) begin : g_stage
      logic [SYM_W-1:0] lower;
      if (gi == 0) begin : g_first
        assign lower = '0;
      end else begin : g_rest
        assign lower = base[gi-1];
      end
      assign r_d[gi] = load_i  ? (lower ^ gf_mul(fb, gen_coef(gi))) :
                       shift_i ? lower : base[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign par_head_o = r_q[NPAR-1];

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(31,27) encoder with valid/ready handshakes and registered output.
// Optional macro RSENC_SHORTEN_EN adds msg_len for shortened codewords.
module rs_encoder #(
  parameter int N = 31,
  parameter int K = 27
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] datain,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] dataout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop
`ifdef RSENC_SHORTEN_EN
  ,
  input  logic [4:0] msg_len
`endif
);

  import rs_pkg::*;

  localparam int KMAX = (K > N - NPAR) ? N - NPAR : K;
  localparam logic [4:0] K_SYM = 5'(KMAX);
  localparam logic [1:0] PAR_LAST = 2'(NPAR - 1);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] len_q, len_d;
  logic [1:0] par_cnt_q, par_cnt_d;
  logic [4:0] dout_q, dout_d;
  logic       out_valid_q, out_valid_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;
  logic       rdy_en_q;

  logic       out_free;
  logic       in_fire;
  logic       lfsr_load, lfsr_shift, lfsr_clear;
  logic [4:0] par_head;
  logic [4:0] len_in;

`ifdef RSENC_SHORTEN_EN
  assign len_in = (msg_len == 5'd0 || msg_len > K_SYM) ? K_SYM : msg_len;
`else
  assign len_in = K_SYM;
`endif

  // rdy_en_q keeps in_ready low until the first edge after reset release.
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = rdy_en_q && (state_q != PARITY) && out_free;
  assign in_fire  = in_valid && in_ready;

  rs_enc_lfsr u_lfsr (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_i    (lfsr_clear),
    .load_i     (lfsr_load),
    .shift_i    (lfsr_shift),
    .sym_i      (datain),
    .par_head_o (par_head)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    par_cnt_d   = par_cnt_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    lfsr_load   = 1'b0;
    lfsr_shift  = 1'b0;
    lfsr_clear  = 1'b0;

    if (out_free) begin
      out_valid_d = 1'b0;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          lfsr_load   = 1'b1;
          dout_d      = datain;
          out_valid_d = 1'b1;
          sop_d       = 1'b1;
          len_d       = len_in;
          if (len_in == 5'd1) begin
            state_d = PARITY;
            cnt_d   = 5'd0;
          end else begin
            state_d = DATA;
            cnt_d   = 5'd1;
          end
        end
      end
      DATA: begin
        if (in_fire) begin
          lfsr_load   = 1'b1;
          dout_d      = datain;
          out_valid_d = 1'b1;
          if (cnt_q == len_q - 5'd1) begin
            state_d = PARITY;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      PARITY: begin
        // Returning to IDLE as r0 is loaded lets the next codeword's first
        // symbol transfer in the same cycle r0 leaves.
        if (out_free) begin
          lfsr_shift  = 1'b1;
          dout_d      = par_head;
          out_valid_d = 1'b1;
          par_cnt_d   = par_cnt_q + 2'd1;
          if (par_cnt_q == PAR_LAST) begin
            eop_d      = 1'b1;
            state_d    = IDLE;
            lfsr_clear = 1'b1;
            par_cnt_d  = 2'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= K_SYM;
      par_cnt_q   <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      par_cnt_q   <= par_cnt_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      rdy_en_q    <= 1'b1;
    end
  end

  assign dataout   = dout_q;
  assign out_valid = out_valid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Scoreboard bench for rs_encoder: stimulus pushes expected codewords, a
// negedge monitor pops and compares every output transfer.
`timescale 1ns/1ps
module tb_rs_encoder;

  localparam int N = 31;
  localparam int K = 27;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [4:0] datain = 5'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] dataout;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sop;
  logic       out_eop;
`ifdef RSENC_SHORTEN_EN
  logic [4:0] msg_len = 5'd0;
`endif

  always #5 clock = ~clock;

  rs_encoder #(.N(N), .K(K)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .datain    (datain),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataout   (dataout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop)
`ifdef RSENC_SHORTEN_EN
    ,
    .msg_len   (msg_len)
`endif
  );

  typedef struct packed {
    logic [4:0] data;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] cw_q[$];
  logic [4:0] msg_buf [K];
  int         n_tests = 0;
  int         n_fail = 0;
  bit         stall_mode = 1'b0;
  bit         gap_mode = 1'b0;

  task automatic chk(input string name, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Carry-less product then reduction by x^5+x^2+1.
  function automatic logic [4:0] gmul(input logic [4:0] a, input logic [4:0] b);
    logic [9:0] p;
    p = '0;
    for (int i = 0; i < 5; i++) if (b[i]) p = p ^ (10'(a) << i);
    for (int i = 9; i >= 5; i--) if (p[i]) p = p ^ (10'b100101 << (i - 5));
    return p[4:0];
  endfunction

  // Long division of x^4*m(x) by g(x); message right-aligned (leading zeros).
  function automatic logic [19:0] model_parity(input int len);
    logic [4:0] c [N];
    logic [4:0] g [5];
    logic [4:0] coef;
    g = '{5'd1, 5'd30, 5'd6, 5'd9, 5'd17};
    for (int i = 0; i < N; i++) c[i] = 5'd0;
    for (int i = 0; i < len; i++) c[K - len + i] = msg_buf[i];
    for (int i = 0; i < K; i++) begin
      coef = c[i];
      for (int j = 1; j < 5; j++) c[i + j] = c[i + j] ^ gmul(coef, g[j]);
    end
    return {c[K], c[K + 1], c[K + 2], c[K + 3]};
  endfunction

  task automatic push_expected(input int len, input logic [19:0] par);
    for (int i = 0; i < len; i++) exp_q.push_back('{msg_buf[i], (i == 0), 1'b0});
    exp_q.push_back('{par[19:15], 1'b0, 1'b0});
    exp_q.push_back('{par[14:10], 1'b0, 1'b0});
    exp_q.push_back('{par[9:5],   1'b0, 1'b0});
    exp_q.push_back('{par[4:0],   1'b0, 1'b1});
  endtask

  // Called at posedge+1; returns at posedge+1 after the last accepted symbol.
  task automatic send_msg(input int cnt);
    logic acc;
    int   guard;
    for (int i = 0; i < cnt; i++) begin
      if (gap_mode) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock);
          #1;
        end
      end
      in_valid = 1'b1;
      datain   = msg_buf[i];
      guard    = 0;
      do begin
        @(negedge clock);
        acc = in_ready;
        @(posedge clock);
        #1;
        guard++;
      end while (!acc && guard < 300);
      if (!acc) begin
        n_tests++;
        n_fail++;
        $display("FAIL in_accept_timeout: got 0 expected 1 (symbol %0d)", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(posedge clock);
      #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic rand_msg(input int len);
    for (int i = 0; i < len; i++) msg_buf[i] = 5'($urandom_range(0, 31));
  endtask

  task automatic zero_msg();
    for (int i = 0; i < K; i++) msg_buf[i] = 5'd0;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      out_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: compare transfers, stall stability, and codeword syndromes.
  initial begin
    exp_t       e;
    exp_t       held;
    bit         held_v;
    logic [4:0] s;
    logic [4:0] aj;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        cw_q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v)
          chk("stall_hold", int'({out_valid, dataout, out_sop, out_eop}),
              int'({1'b1, held.data, held.sop, held.eop}));
        held_v = out_valid && !out_ready;
        held   = '{dataout, out_sop, out_eop};
        if (out_valid && out_ready) begin
          $display("[TB] out sym=%0d sop=%0d eop=%0d", dataout, out_sop, out_eop);
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_sym{data,sop,eop}", int'({dataout, out_sop, out_eop}),
                int'({e.data, e.sop, e.eop}));
          end
          cw_q.push_back(dataout);
          if (out_eop) begin
            chk("in_ready_at_eop", int'(in_ready), 1);
            aj = 5'd1;
            for (int j = 1; j <= 4; j++) begin
              aj = gmul(aj, 5'd2);
              s  = 5'd0;
              foreach (cw_q[k]) s = gmul(s, aj) ^ cw_q[k];
              chk($sformatf("syndrome_a%0d", j), int'(s), 0);
            end
            cw_q.delete();
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, including asynchronous assertion.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_dataout",   int'(dataout),   0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sop",   int'(out_sop),   0);
    chk("rst_out_eop",   int'(out_eop),   0);
    chk("rst_in_ready",  int'(in_ready),  0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1 chk("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clock);
    #1;

    // All-zero message, then 26 zeros + 1, then 26 zeros + 2, back-to-back.
    zero_msg();
    push_expected(K, {5'd0, 5'd0, 5'd0, 5'd0});
    send_msg(K);
    msg_buf[K-1] = 5'd1;
    push_expected(K, {5'd30, 5'd6, 5'd9, 5'd17});
    send_msg(K);
    msg_buf[K-1] = 5'd2;
    push_expected(K, {5'd25, 5'd12, 5'd18, 5'd7});
    send_msg(K);
    wait_drain();

    // Random messages under output stalls and input gaps.
    stall_mode = 1'b1;
    gap_mode   = 1'b1;
    for (int m = 0; m < 3; m++) begin
      rand_msg(K);
      push_expected(K, model_parity(K));
      send_msg(K);
    end
    wait_drain();
    stall_mode = 1'b0;
    gap_mode   = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset after the tenth message symbol, then a fresh codeword.
    rand_msg(K);
    push_expected(K, model_parity(K));
    send_msg(10);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_dataout",   int'(dataout),   0);
    chk("midrst_out_sop",   int'(out_sop),   0);
    chk("midrst_in_ready",  int'(in_ready),  0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    rand_msg(K);
    push_expected(K, model_parity(K));
    send_msg(K);
    wait_drain();

`ifdef RSENC_SHORTEN_EN
    msg_len    = 5'd1;
    msg_buf[0] = 5'd1;
    push_expected(1, {5'd30, 5'd6, 5'd9, 5'd17});
    send_msg(1);
    wait_drain();
    msg_len = 5'd5;
    rand_msg(5);
    push_expected(5, model_parity(5));
    send_msg(5);
    wait_drain();
    msg_len = 5'd0;
    rand_msg(K);
    push_expected(K, model_parity(K));
    send_msg(K);
    wait_drain();
`endif

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
